// File: rtl/mole_scorer.sv
// Whack-a-mole scorer: latches the mole pattern each round, debounces the player buttons,
// and keeps a saturating BCD hit score and a binary miss count.
module mole_scorer #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned ROUND_CYCLES    = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       EN,
  input  logic [7:0] mole_n,
  input  logic [7:0] btn_n,
  output logic [7:0] led_n,
  output logic [7:0] score,
  output logic [3:0] misses,
  output logic       hit,
  output logic       miss,
  output logic       round_done,
  output logic       busy
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StArm  = 2'd1;
  localparam logic [1:0] StWait = 2'd2;
  localparam logic [1:0] StEnd  = 2'd3;

  localparam logic [3:0] DebTarget = 4'(DEBOUNCE_CYCLES);
  localparam logic [7:0] TimerLoad = 8'(ROUND_CYCLES - 1);

  logic [7:0] sync1_q, sync2_q;
  logic [3:0] cnt_q [8];
  logic [7:0] pressed, pressed_q, pe;

  logic [1:0] state_q, state_d;
  logic [7:0] mask_q, mask_d;
  logic [7:0] timer_q, timer_d;
  logic [7:0] score_q, score_d;
  logic [3:0] misses_q, misses_d;
  logic       hit_q, hit_d;
  logic       miss_q, miss_d;
  logic [7:0] hits, strays;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 8; i++) begin
      c = c + {3'd0, v[i]};
    end
    return c;
  endfunction

  // n is at most 8, so the units digit can carry at most once.
  function automatic logic [7:0] bcd_add(input logic [7:0] s, input logic [3:0] n);
    logic [4:0] u;
    logic [4:0] t;
    u = {1'b0, s[3:0]} + {1'b0, n};
    t = {1'b0, s[7:4]};
    if (u > 5'd9) begin
      u = u - 5'd10;
      t = t + 5'd1;
    end
    if (t > 5'd9) begin
      return 8'h99;
    end
    return {t[3:0], u[3:0]};
  endfunction

  // Buttons idle high, so the synchronisers reset to all ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= 8'hFF;
      sync2_q   <= 8'hFF;
      pressed_q <= 8'h00;
      for (int i = 0; i < 8; i++) begin
        cnt_q[i] <= 4'd0;
      end
    end else begin
      sync1_q   <= btn_n;
      sync2_q   <= sync1_q;
      pressed_q <= pressed;
      for (int i = 0; i < 8; i++) begin
        if (sync2_q[i]) begin
          cnt_q[i] <= 4'd0;
        end else if (cnt_q[i] != 4'hF) begin
          cnt_q[i] <= cnt_q[i] + 4'd1;
        end
      end
    end
  end

  always_comb begin
    pressed = 8'h00;
    for (int i = 0; i < 8; i++) begin
      pressed[i] = (cnt_q[i] == DebTarget);
    end
  end

  assign pe     = pressed & ~pressed_q;
  assign hits   = pe & mask_q;
  assign strays = pe & ~mask_q;

  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    timer_d  = timer_q;
    score_d  = score_q;
    misses_d = misses_q;
    hit_d    = 1'b0;
    miss_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (EN) begin
          state_d = StArm;
        end
      end
      StArm: begin
        if (!EN) begin
          state_d = StIdle;
        end else begin
          mask_d = ~mole_n;
          if (mole_n != 8'hFF) begin
            timer_d = TimerLoad;
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (!EN) begin
          state_d = StIdle;
        end else begin
          if (hits != 8'h00) begin
            mask_d  = mask_q & ~hits;
            score_d = bcd_add(score_q, popcount8(hits));
            hit_d   = 1'b1;
          end
          if (strays != 8'h00) begin
            if (misses_q != 4'hF) begin
              misses_d = misses_q + 4'd1;
            end
            miss_d = 1'b1;
          end
          if (mask_d == 8'h00 || timer_q == 8'd0) begin
            state_d = StEnd;
          end else begin
            timer_d = timer_q - 8'd1;
          end
        end
      end
      StEnd: begin
        state_d = EN ? StArm : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      mask_q   <= 8'h00;
      timer_q  <= 8'd0;
      score_q  <= 8'h00;
      misses_q <= 4'd0;
      hit_q    <= 1'b0;
      miss_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      timer_q  <= timer_d;
      score_q  <= score_d;
      misses_q <= misses_d;
      hit_q    <= hit_d;
      miss_q   <= miss_d;
    end
  end

  assign led_n      = (state_q == StWait) ? ~mask_q : 8'hFF;
  assign busy       = (state_q == StWait);
  assign round_done = (state_q == StEnd);
  assign score      = score_q;
  assign misses     = misses_q;
  assign hit        = hit_q;
  assign miss       = miss_q;

endmodule

// File: tb/tb_mole_scorer.sv
// Directed bench for mole_scorer with DEBOUNCE_CYCLES=2, ROUND_CYCLES=20.
module tb_mole_scorer;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] mole_n;
  logic [7:0] btn_n;
  logic [7:0] led_n;
  logic [7:0] score;
  logic [3:0] misses;
  logic       hit;
  logic       miss;
  logic       round_done;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;

  mole_scorer #(
    .DEBOUNCE_CYCLES(2),
    .ROUND_CYCLES   (20)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .EN        (en),
    .mole_n    (mole_n),
    .btn_n     (btn_n),
    .led_n     (led_n),
    .score     (score),
    .misses    (misses),
    .hit       (hit),
    .miss      (miss),
    .round_done(round_done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Any state reaches IDLE within one edge once EN drops; extra edges flush the debouncers.
  task automatic go_idle();
    en    = 1'b0;
    btn_n = 8'hFF;
    repeat (4) step();
  endtask

  task automatic arm(input logic [7:0] m);
    mole_n = m;
    en     = 1'b1;
    step();
    step();
  endtask

  // First low sample at the next edge; the hit/miss registers update 4 edges later.
  task automatic press(input logic [7:0] bits);
    btn_n = ~bits;
    repeat (5) step();
  endtask

  task automatic hit_round(input logic [7:0] bits);
    go_idle();
    arm(~bits);
    press(bits);
  endtask

  initial begin
    rst    = 1'b1;
    en     = 1'b0;
    mole_n = 8'hFF;
    btn_n  = 8'hFF;
    repeat (3) step();
    check_eq("rst_led_n", led_n, 8'hFF);
    check_eq("rst_score", score, 8'h00);
    check_eq("rst_misses", {4'h0, misses}, 8'h00);
    check_eq("rst_hit", {7'd0, hit}, 8'h00);
    check_eq("rst_miss", {7'd0, miss}, 8'h00);
    check_eq("rst_round_done", {7'd0, round_done}, 8'h00);
    check_eq("rst_busy", {7'd0, busy}, 8'h00);
    rst = 1'b0;

    // Arm with mask 0x01, then single hit.
    arm(8'hFE);
    check_eq("arm_busy", {7'd0, busy}, 8'h01);
    check_eq("arm_led_n", led_n, 8'hFE);
    btn_n = 8'hFE;
    repeat (4) begin
      step();
      check_eq("hit_early", {7'd0, hit}, 8'h00);
    end
    step();
    check_eq("single_hit", {7'd0, hit}, 8'h01);
    check_eq("single_score", score, 8'h01);
    check_eq("single_done", {7'd0, round_done}, 8'h01);
    check_eq("single_led_n", led_n, 8'hFF);
    step();
    check_eq("hit_once", {7'd0, hit}, 8'h00);

    // Miss then timeout.
    go_idle();
    arm(8'h7E);
    check_eq("miss_led_n", led_n, 8'h7E);
    press(8'h08);
    check_eq("miss_pulse", {7'd0, miss}, 8'h01);
    check_eq("miss_no_hit", {7'd0, hit}, 8'h00);
    check_eq("miss_count", {4'h0, misses}, 8'h01);
    check_eq("miss_score", score, 8'h01);
    btn_n = 8'hFF;
    repeat (14) step();
    check_eq("timeout_not_yet", {7'd0, round_done}, 8'h00);
    check_eq("timeout_busy", {7'd0, busy}, 8'h01);
    step();
    check_eq("timeout_done", {7'd0, round_done}, 8'h01);
    check_eq("timeout_led_n", led_n, 8'hFF);

    // Bits 0,1 hit and bit 4 misses in the same cycle.
    go_idle();
    arm(8'hF0);
    press(8'h13);
    check_eq("simul_score", score, 8'h03);
    check_eq("simul_misses", {4'h0, misses}, 8'h02);
    check_eq("simul_hit", {7'd0, hit}, 8'h01);
    check_eq("simul_miss", {7'd0, miss}, 8'h01);
    check_eq("simul_led_n", led_n, 8'hF3);
    check_eq("simul_not_done", {7'd0, round_done}, 8'h00);

    // BCD carry and saturation.
    hit_round(8'h3F);
    check_eq("score_09", score, 8'h09);
    hit_round(8'h01);
    check_eq("score_carry", score, 8'h10);
    repeat (11) hit_round(8'hFF);
    check_eq("score_98", score, 8'h98);
    hit_round(8'h07);
    check_eq("score_99", score, 8'h99);
    hit_round(8'h01);
    check_eq("score_sat", score, 8'h99);

    // Abort by dropping EN in WAIT.
    go_idle();
    arm(8'hFE);
    en = 1'b0;
    step();
    check_eq("abort_busy", {7'd0, busy}, 8'h00);
    check_eq("abort_led_n", led_n, 8'hFF);
    check_eq("abort_score", score, 8'h99);
    check_eq("abort_misses", {4'h0, misses}, 8'h02);

    // Reset in WAIT while a press event is being evaluated.
    arm(8'hFE);
    btn_n = 8'hFE;
    repeat (4) step();
    rst = 1'b1;
    step();
    check_eq("midrst_hit", {7'd0, hit}, 8'h00);
    check_eq("midrst_score", score, 8'h00);
    check_eq("midrst_misses", {4'h0, misses}, 8'h00);
    check_eq("midrst_busy", {7'd0, busy}, 8'h00);
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
